// File: rtl/mshr_refill_ctrl.sv
// Single-entry miss handler for the non-blocking data cache: victim writeback,
// metadata invalidate, acquire/refill, final metadata write and request replay.
module mshr_refill_ctrl #(
  parameter int TAG_W        = 20,
  parameter int IDX_W        = 6,
  parameter int WAYS         = 4,
  parameter int REFILL_BEATS = 4,
  parameter int BEAT_W       = $clog2(REFILL_BEATS)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_cmd,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic [WAYS-1:0]   req_way_en,
  input  logic              req_tag_match,
  input  logic [1:0]        req_old_coh,
  input  logic [TAG_W-1:0]  req_old_tag,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [IDX_W-1:0]  wb_idx,
  output logic [WAYS-1:0]   wb_way_en,
  input  logic              wb_done,

  output logic              acq_valid,
  input  logic              acq_ready,
  output logic [TAG_W-1:0]  acq_tag,
  output logic [IDX_W-1:0]  acq_idx,
  output logic              acq_excl,

  input  logic              grant_valid,
  output logic              refill_we,
  output logic [WAYS-1:0]   refill_way_en,
  output logic [BEAT_W-1:0] refill_beat,

  output logic              meta_wvalid,
  input  logic              meta_wready,
  output logic [IDX_W-1:0]  meta_widx,
  output logic [WAYS-1:0]   meta_wway_en,
  output logic [TAG_W-1:0]  meta_wtag,
  output logic [1:0]        meta_wcoh,

  output logic              replay_valid,
  input  logic              replay_ready,
  output logic [4:0]        replay_cmd,

  output logic              busy,
  input  logic [IDX_W-1:0]  s1_idx,
  output logic              s1_idx_conflict
);

  // Memory command encodings shared with the pipeline.
  localparam logic [4:0] M_XWR     = 5'b00001;
  localparam logic [4:0] M_PFW     = 5'b00011;
  localparam logic [4:0] M_XA_SWAP = 5'b00100;
  localparam logic [4:0] M_XLR     = 5'b00110;
  localparam logic [4:0] M_XSC     = 5'b00111;

  localparam logic [1:0] COH_INVALID = 2'd0;
  localparam logic [1:0] COH_SHARED  = 2'd1;
  localparam logic [1:0] COH_EXCL    = 2'd2;
  localparam logic [1:0] COH_DIRTY   = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REFILL_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_META_CLR,
    S_ACQ,
    S_REFILL,
    S_META_WR,
    S_REPLAY
  } state_t;

  state_t state, state_nxt;

  logic [4:0]        cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WAYS-1:0]   way_en_q;
  logic              tag_match_q;
  logic [1:0]        old_coh_q;
  logic [TAG_W-1:0]  old_tag_q;
  logic [BEAT_W-1:0] beat_q;

  logic accept;
  logic write_intent;
  logic is_write;
  logic [1:0] final_coh;

  assign accept = req_valid && req_ready;

  always_comb begin
    is_write     = (cmd_q == M_XWR) || (cmd_q == M_XSC) || (cmd_q == M_XA_SWAP) || cmd_q[3];
    write_intent = is_write || (cmd_q == M_PFW) || (cmd_q == M_XLR);
    final_coh    = is_write ? COH_DIRTY : (write_intent ? COH_EXCL : COH_SHARED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // The request fields are cleared on reset so no stale address is ever presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= '0;
      tag_q       <= '0;
      idx_q       <= '0;
      way_en_q    <= '0;
      tag_match_q <= 1'b0;
      old_coh_q   <= COH_INVALID;
      old_tag_q   <= '0;
    end else if (accept) begin
      cmd_q       <= req_cmd;
      tag_q       <= req_tag;
      idx_q       <= req_idx;
      way_en_q    <= req_way_en;
      tag_match_q <= req_tag_match;
      old_coh_q   <= req_old_coh;
      old_tag_q   <= req_old_tag;
    end
  end

  // Beat counter wraps naturally because REFILL_BEATS is a power of two.
  always_ff @(posedge clk) begin
    if (reset)
      beat_q <= '0;
    else if (state == S_ACQ && acq_ready)
      beat_q <= '0;
    else if (state == S_REFILL && grant_valid)
      beat_q <= beat_q + 1'b1;
  end

  // Only a dirty, non-upgrade victim can reach the writeback wait.
  always_ff @(posedge clk) begin
    if (!reset && state == S_WB_WAIT)
      assert (!tag_match_q && old_coh_q == COH_DIRTY);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (req_valid) begin
          if (!req_tag_match && req_old_coh == COH_DIRTY) state_nxt = S_WB_REQ;
          else if (!req_tag_match)                        state_nxt = S_META_CLR;
          else                                            state_nxt = S_ACQ;
        end
      S_WB_REQ:   if (wb_ready)                        state_nxt = S_WB_WAIT;
      S_WB_WAIT:  if (wb_done)                         state_nxt = S_META_CLR;
      S_META_CLR: if (meta_wready)                     state_nxt = S_ACQ;
      S_ACQ:      if (acq_ready)                       state_nxt = S_REFILL;
      S_REFILL:   if (grant_valid && beat_q == LAST_BEAT) state_nxt = S_META_WR;
      S_META_WR:  if (meta_wready)                     state_nxt = S_REPLAY;
      S_REPLAY:   if (replay_ready)                    state_nxt = S_IDLE;
      default:                                         state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b1;
    wb_valid     = 1'b0;
    acq_valid    = 1'b0;
    refill_we    = 1'b0;
    meta_wvalid  = 1'b0;
    meta_wtag    = tag_q;
    meta_wcoh    = COH_INVALID;
    replay_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WB_REQ: wb_valid = 1'b1;
      S_META_CLR: begin
        meta_wvalid = 1'b1;
        meta_wtag   = old_tag_q;
        meta_wcoh   = COH_INVALID;
      end
      S_ACQ:    acq_valid = 1'b1;
      S_REFILL: refill_we = grant_valid;
      S_META_WR: begin
        meta_wvalid = 1'b1;
        meta_wtag   = tag_q;
        meta_wcoh   = final_coh;
      end
      S_REPLAY: replay_valid = 1'b1;
      default: ;
    endcase
  end

  assign wb_tag          = old_tag_q;
  assign wb_idx          = idx_q;
  assign wb_way_en       = way_en_q;
  assign acq_tag         = tag_q;
  assign acq_idx         = idx_q;
  assign acq_excl        = write_intent;
  assign refill_way_en   = way_en_q;
  assign refill_beat     = beat_q;
  assign meta_widx       = idx_q;
  assign meta_wway_en    = way_en_q;
  assign replay_cmd      = cmd_q;
  assign s1_idx_conflict = busy && (s1_idx == idx_q);

endmodule

// File: tb/tb_mshr_refill_ctrl.sv
// Randomised scoreboard bench for mshr_refill_ctrl: a request-level model queues
// the expected handshake events and a monitor pops them as the DUT presents them.
module tb_mshr_refill_ctrl;

  localparam logic [4:0] M_XRD     = 5'd0;
  localparam logic [4:0] M_XWR     = 5'd1;
  localparam logic [4:0] M_PFW     = 5'd3;
  localparam logic [4:0] M_XA_SWAP = 5'd4;
  localparam logic [4:0] M_XLR     = 5'd6;
  localparam logic [4:0] M_XSC     = 5'd7;

  localparam int EV_WB = 1, EV_META = 2, EV_ACQ = 3, EV_BEAT = 4, EV_REPLAY = 5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [19:0] tag;
    logic [5:0]  idx;
    logic [3:0]  way;
    logic [4:0]  val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready;
  logic [4:0] req_cmd;
  logic [19:0] req_tag, req_old_tag;
  logic [5:0] req_idx;
  logic [3:0] req_way_en;
  logic req_tag_match;
  logic [1:0] req_old_coh;
  logic wb_valid, wb_ready, wb_done;
  logic [19:0] wb_tag;
  logic [5:0] wb_idx;
  logic [3:0] wb_way_en;
  logic acq_valid, acq_ready, acq_excl;
  logic [19:0] acq_tag;
  logic [5:0] acq_idx;
  logic grant_valid, refill_we;
  logic [3:0] refill_way_en;
  logic [1:0] refill_beat;
  logic meta_wvalid, meta_wready;
  logic [5:0] meta_widx;
  logic [3:0] meta_wway_en;
  logic [19:0] meta_wtag;
  logic [1:0] meta_wcoh;
  logic replay_valid, replay_ready;
  logic [4:0] replay_cmd;
  logic busy, s1_idx_conflict;
  logic [5:0] s1_idx;

  mshr_refill_ctrl #(.TAG_W(20), .IDX_W(6), .WAYS(4), .REFILL_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_tag(req_tag),
    .req_idx(req_idx), .req_way_en(req_way_en), .req_tag_match(req_tag_match),
    .req_old_coh(req_old_coh), .req_old_tag(req_old_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_idx(wb_idx),
    .wb_way_en(wb_way_en), .wb_done(wb_done),
    .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_tag(acq_tag), .acq_idx(acq_idx),
    .acq_excl(acq_excl),
    .grant_valid(grant_valid), .refill_we(refill_we), .refill_way_en(refill_way_en),
    .refill_beat(refill_beat),
    .meta_wvalid(meta_wvalid), .meta_wready(meta_wready), .meta_widx(meta_widx),
    .meta_wway_en(meta_wway_en), .meta_wtag(meta_wtag), .meta_wcoh(meta_wcoh),
    .replay_valid(replay_valid), .replay_ready(replay_ready), .replay_cmd(replay_cmd),
    .busy(busy), .s1_idx(s1_idx), .s1_idx_conflict(s1_idx_conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  ev_t exp_q[$];

  function automatic logic is_wr(input logic [4:0] c);
    return c == M_XWR || c == M_XSC || c == M_XA_SWAP || c[3];
  endfunction

  function automatic logic is_wi(input logic [4:0] c);
    return is_wr(c) || c == M_PFW || c == M_XLR;
  endfunction

  function automatic ev_t mk(input int k, input logic [19:0] t, input logic [5:0] i,
                             input logic [3:0] w, input logic [4:0] v);
    ev_t e;
    e.kind = 3'(k);
    e.tag  = t;
    e.idx  = i;
    e.way  = w;
    e.val  = v;
    return e;
  endfunction

  task automatic model_push(input logic [4:0] cmd, input logic [19:0] tag, input logic [5:0] idx,
                            input logic [3:0] way, input logic tm, input logic [1:0] coh,
                            input logic [19:0] otag);
    logic [1:0] fcoh;
    fcoh = is_wr(cmd) ? 2'd3 : (is_wi(cmd) ? 2'd2 : 2'd1);
    if (!tm && coh == 2'd3) exp_q.push_back(mk(EV_WB, otag, idx, way, 5'd0));
    if (!tm)                exp_q.push_back(mk(EV_META, otag, idx, way, 5'd0));
    exp_q.push_back(mk(EV_ACQ, tag, idx, 4'd0, 5'(is_wi(cmd))));
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(EV_BEAT, 20'd0, 6'd0, way, 5'(b)));
    exp_q.push_back(mk(EV_META, tag, idx, way, 5'(fcoh)));
    exp_q.push_back(mk(EV_REPLAY, 20'd0, 6'd0, 4'd0, cmd));
  endtask

  // ---------------- environment (ready/grant/wb_done responders) ----------------
  int rdy_pct = 100;
  int grant_pct = 100;
  int wb_delay = 2;
  bit noise = 0;
  int wb_cnt = -1;
  bit meta_script[$];
  bit grant_script[$];

  function automatic logic pick(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  initial begin : env
    forever begin
      @(negedge clk);
      if (!reset && wb_valid && wb_ready) wb_cnt = wb_delay;
      @(posedge clk);
      #1;
      wb_done = 1'b0;
      if (wb_cnt == 0) begin
        wb_done = 1'b1;
        wb_cnt  = -1;
      end else if (wb_cnt > 0) begin
        wb_cnt--;
      end else if (noise && $urandom_range(0, 7) == 0) begin
        wb_done = 1'b1;
      end
      wb_ready     = pick(rdy_pct);
      acq_ready    = pick(rdy_pct);
      replay_ready = pick(rdy_pct);
      meta_wready  = (meta_script.size() != 0) ? meta_script.pop_front() : pick(rdy_pct);
      grant_valid  = (grant_script.size() != 0) ? grant_script.pop_front() : pick(grant_pct);
    end
  end

  // ---------------- monitor ----------------
  bit wb_seen = 0;
  bit hold_prev = 0;
  logic [63:0] hold_snap;

  task automatic observe(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("event_expected_kind%0d", got.kind), 64'(exp_q.size() != 0), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind%0d", e.kind), 64'(got), 64'(e));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 0;
      end else begin
        if (wb_valid) wb_seen = 1;
        if (hold_prev)
          check("meta_hold", 64'({meta_wvalid, meta_wtag, meta_widx, meta_wway_en, meta_wcoh}), hold_snap);
        hold_prev = meta_wvalid && !meta_wready;
        hold_snap = 64'({meta_wvalid, meta_wtag, meta_widx, meta_wway_en, meta_wcoh});
        if (wb_valid && wb_ready)       observe(mk(EV_WB, wb_tag, wb_idx, wb_way_en, 5'd0));
        if (meta_wvalid && meta_wready) observe(mk(EV_META, meta_wtag, meta_widx, meta_wway_en, 5'(meta_wcoh)));
        if (acq_valid && acq_ready)     observe(mk(EV_ACQ, acq_tag, acq_idx, 4'd0, 5'(acq_excl)));
        if (refill_we)                  observe(mk(EV_BEAT, 20'd0, 6'd0, refill_way_en, 5'(refill_beat)));
        if (replay_valid && replay_ready) observe(mk(EV_REPLAY, 20'd0, 6'd0, 4'd0, replay_cmd));
      end
    end
  end

  // ---------------- stimulus ----------------
  int accept_cyc;

  task automatic issue(input logic [4:0] cmd, input logic [19:0] tag, input logic [5:0] idx,
                       input logic [3:0] way, input logic tm, input logic [1:0] coh,
                       input logic [19:0] otag);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_cmd = cmd; req_tag = tag; req_idx = idx;
    req_way_en = way; req_tag_match = tm; req_old_coh = coh; req_old_tag = otag;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
    else begin
      model_push(cmd, tag, idx, way, tm, coh, otag);
      accept_cyc = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    #1;
    while (!(exp_q.size() == 0 && !busy) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int lat;
    reset = 1'b1;
    req_valid = 0; req_cmd = 0; req_tag = 0; req_idx = 0; req_way_en = 0;
    req_tag_match = 0; req_old_coh = 0; req_old_tag = 0;
    wb_ready = 0; wb_done = 0; acq_ready = 0; grant_valid = 0;
    meta_wready = 0; replay_ready = 0; s1_idx = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valids", 64'({wb_valid, acq_valid, refill_we, meta_wvalid, replay_valid}), 64'd0);
    check("rst_conflict", 64'(s1_idx_conflict), 64'd0);

    // Dirty miss with writeback.
    wb_delay = 2;
    issue(M_XRD, 20'h12345, 6'h15, 4'b0100, 1'b0, 2'd3, 20'hABCDE);
    wait_idle("dirty");

    // Clean miss with store: no writeback, 8-cycle turnaround.
    wb_seen = 0;
    issue(M_XWR, 20'h0F0F0, 6'h2A, 4'b0010, 1'b0, 2'd2, 20'h11111);
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - accept_cyc - 1;
    check("clean_latency", 64'(lat), 64'd8);
    wait_idle("clean");
    check("clean_no_wb", 64'(wb_seen), 64'd0);

    // Upgrade: straight to acquire.
    wb_seen = 0;
    issue(M_XA_SWAP, 20'h55AA5, 6'h03, 4'b1000, 1'b1, 2'd1, 20'h55AA5);
    @(negedge clk);
    #1;
    check("upg_first_acq", 64'(acq_valid), 64'd1);
    check("upg_no_wb_meta", 64'({wb_valid, meta_wvalid}), 64'd0);
    wait_idle("upgrade");
    check("upg_no_wb", 64'(wb_seen), 64'd0);

    // Backpressure on metadata and gapped grants.
    grant_pct = 0;
    repeat (6) meta_script.push_back(1'b0);
    issue(M_XLR, 20'h3C3C3, 6'h11, 4'b0001, 1'b0, 2'd1, 20'h7E7E7);
    n = 0;
    @(negedge clk);
    while (!(acq_valid && acq_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_acq_seen", 64'(acq_valid && acq_ready), 64'd1);
    grant_script = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wait_idle("backpressure");

    // Stray grants and wb_done while idle.
    noise = 1; grant_pct = 50; rdy_pct = 50;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_noise_busy", 64'(busy), 64'd0);
    noise = 0; grant_pct = 100; rdy_pct = 100;

    // Conflict and no-accept while busy.
    rdy_pct = 0;
    issue(M_XRD, 20'h00ABC, 6'h15, 4'b0100, 1'b0, 2'd3, 20'h00DEF);
    @(negedge clk);
    s1_idx = 6'h15;
    #1 check("conflict_hit", 64'(s1_idx_conflict), 64'd1);
    s1_idx = 6'h16;
    #1 check("conflict_miss", 64'(s1_idx_conflict), 64'd0);
    req_valid = 1'b1; req_cmd = M_XWR; req_idx = 6'h3F; req_tag_match = 1'b1;
    #1 check("busy_no_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rdy_pct = 100;
    wait_idle("conflict");

    // Reset in the middle of a refill.
    issue(M_XRD, 20'hBEEF1, 6'h07, 4'b0010, 1'b0, 2'd1, 20'h22222);
    n = 0;
    @(negedge clk);
    while (!(refill_we && refill_beat == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rr_beat1_seen", 64'(refill_we && refill_beat == 2'd1), 64'd1);
    grant_pct = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_req_ready", 64'(req_ready), 64'd1);
    grant_pct = 100;
    issue(M_PFW, 20'hC0FFE, 6'h09, 4'b0001, 1'b0, 2'd0, 20'h33333);
    wait_idle("after_reset");

    // Randomised misses with random handshake timing and noise.
    rdy_pct = 70; grant_pct = 60; noise = 1;
    for (int i = 0; i < 30; i++) begin
      wb_delay = $urandom_range(0, 5);
      issue(5'($urandom_range(0, 31)), 20'($urandom), 6'($urandom), 4'(1 << $urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 20'($urandom));
      wait_idle($sformatf("rand%0d", i));
    end
    noise = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
